// File: rtl/return_address_stack.sv
// Return-address stack for the fetch/decode stage.
// A circular LIFO of subroutine return addresses with a top pointer and an
// occupancy counter. A push into a full stack overwrites the oldest entry.
// A pop from an empty stack changes nothing. Both cases raise sticky error
// flags that only reset clears. top_addr is combinational, so a RET can use
// its target in the same cycle that it pops.
module return_address_stack #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         stall,
  input  logic [ADDR_WIDTH-1:0]        push_addr,
  output logic [ADDR_WIDTH-1:0]        top_addr,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         sp_q, sp_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  do_push, do_pop;
  logic                  empty_w, full_w;
  logic [PW-1:0]         sp_inc, sp_dec;
  logic                  wr_en;
  logic [PW-1:0]         wr_idx;
  logic [ADDR_WIDTH-1:0] wr_data;

  // A stalled request is dropped outright; the caller re-presents it.
  assign do_push = push & ~stall;
  assign do_pop  = pop & ~stall;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // The pointer is exactly log2(DEPTH) bits wide, so it wraps for free.
  assign sp_inc = sp_q + PW'(1);
  assign sp_dec = sp_q - PW'(1);

  // Next-state: pointer, occupancy, sticky flags and the single write port.
  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    wr_idx      = sp_q;
    wr_data     = push_addr;

    if (do_push && do_pop && !empty_w) begin
      // Replace top: the return just taken is swapped for the new call.
      wr_en  = 1'b1;
      wr_idx = sp_q;
    end else if (do_push) begin
      // Plain push. A push+pop on an empty stack also lands here and
      // deliberately leaves underflow alone.
      sp_d   = sp_inc;
      wr_en  = 1'b1;
      wr_idx = sp_inc;
      if (full_w) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (do_pop) begin
      if (empty_w) begin
        underflow_d = 1'b1;
      end else begin
        sp_d    = sp_dec;
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state. sp resets to DEPTH-1 so the first push lands in entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q        <= PW'(DEPTH - 1);
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage. It needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign top_addr  = empty_w ? '0 : mem_q[sp_q];
  assign count     = count_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
